// File: rtl/fir_pkg.sv
// Shared types, defaults and width helpers for the TDM multi-channel FIR.
// Saturation is selected at build time with the FIR_SAT_EN macro.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_state_t;

  localparam int DEF_TAPS     = 16;
  localparam int DEF_BIT_PREC = 16;
  localparam int DEF_CHANNELS = 4;

  // Full product width plus enough guard bits to sum every tap without overflow.
  function automatic int fir_acc_w(input int bit_prec, input int taps);
    return 2 * bit_prec + $clog2(taps);
  endfunction

  typedef logic signed [DEF_BIT_PREC-1:0]                        sample_t;
  typedef logic signed [DEF_BIT_PREC-1:0]                        coef_t;
  typedef logic signed [fir_acc_w(DEF_BIT_PREC, DEF_TAPS)-1:0]   acc_t;

endpackage

// File: rtl/fir_mac_unit.sv
// Shared multiply-accumulate datapath with round-half-up output shift.
// FIR_SAT_EN builds an output clamp; otherwise the result wraps to OUT_W.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int BIT_PREC  = DEF_BIT_PREC,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 15,
  parameter int ACC_W     = fir_acc_w(DEF_BIT_PREC, DEF_TAPS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic signed [BIT_PREC-1:0] coef,
  input  logic signed [BIT_PREC-1:0] sample,
  output logic signed [OUT_W-1:0]    result
);

  localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1) << (OUT_SHIFT - 1);
`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX  = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] OUT_MIN  = -(ACC_W'(1) << (OUT_W - 1));
`endif

  logic signed [2*BIT_PREC-1:0] prod;
  logic signed [ACC_W-1:0]      prod_ext;
  logic signed [ACC_W-1:0]      acc;

  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
    return (a + RND_BIAS) >>> OUT_SHIFT;
  endfunction

  function automatic logic signed [OUT_W-1:0] reduce_out(input logic signed [ACC_W-1:0] r);
`ifdef FIR_SAT_EN
    if (r > OUT_MAX) return OUT_W'(OUT_MAX);
    if (r < OUT_MIN) return OUT_W'(OUT_MIN);
`endif
    return OUT_W'(r);
  endfunction

  assign prod     = coef * sample;
  assign prod_ext = {{(ACC_W - 2*BIT_PREC){prod[2*BIT_PREC-1]}}, prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + prod_ext;
  end

  assign result = reduce_out(round_shift(acc));

endmodule

// File: rtl/fir_tdm.sv
// Time-multiplexed multi-channel FIR: control FSM, per-channel circular
// histories and a shared run-time coefficient bank around one MAC unit.
module fir_tdm
  import fir_pkg::*;
#(
  parameter int BIT_PREC  = DEF_BIT_PREC,
  parameter int TAPS      = DEF_TAPS,
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 15,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW       = $clog2(TAPS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CH_W-1:0]            in_chan,
  input  logic signed [BIT_PREC-1:0] in_sample,
  input  logic                       coef_we,
  input  logic [AW-1:0]              coef_addr,
  input  logic signed [BIT_PREC-1:0] coef_data,
  output logic                       coef_drop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CH_W-1:0]            out_chan,
  output logic signed [OUT_W-1:0]    out_sample,
  output logic                       busy
);

  localparam int ACC_W = fir_acc_w(BIT_PREC, TAPS);
  localparam int KW    = $clog2(TAPS + 1);

  fir_state_t                 state;
  logic [KW-1:0]              k;
  logic [CH_W-1:0]            ch_r;
  logic [AW-1:0]              wp   [CHANNELS];
  logic signed [BIT_PREC-1:0] hist [CHANNELS][TAPS];
  logic signed [BIT_PREC-1:0] coef [TAPS];

  logic                       chan_ok;
  logic                       accept;
  logic                       mac_en;
  logic [AW-1:0]              tap_idx;
  logic [AW-1:0]              rd_idx;
  int                         rd_tmp;
  logic signed [OUT_W-1:0]    mac_result;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign chan_ok  = int'(in_chan) < CHANNELS;
  assign accept   = in_ready && in_valid && chan_ok;
  // k runs one past the last tap so the final product lands before the output is captured.
  assign mac_en   = (state == MAC) && (k != KW'(TAPS));
  assign tap_idx  = (k == KW'(TAPS)) ? '0 : AW'(k);

  // Tap k reads the sample written k acceptances ago on this channel.
  always_comb begin
    rd_tmp = int'(wp[ch_r]) - int'(k);
    if (rd_tmp < 0) rd_tmp = rd_tmp + TAPS;
    rd_idx = AW'(rd_tmp);
  end

  fir_mac_unit #(
    .BIT_PREC  (BIT_PREC),
    .OUT_W     (OUT_W),
    .OUT_SHIFT (OUT_SHIFT),
    .ACC_W     (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (mac_en),
    .coef   (coef[tap_idx]),
    .sample (hist[ch_r][rd_idx]),
    .result (mac_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      ch_r       <= '0;
      out_valid  <= 1'b0;
      out_chan   <= '0;
      out_sample <= '0;
      coef_drop  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        wp[c] <= '0;
        for (int t = 0; t < TAPS; t++) hist[c][t] <= '0;
      end
      for (int t = 0; t < TAPS; t++) coef[t] <= '0;
    end else begin
      coef_drop <= coef_we && (state != IDLE);
      if (coef_we && state == IDLE) coef[coef_addr] <= coef_data;
      case (state)
        IDLE: begin
          if (accept) begin
            hist[in_chan][wp[in_chan]] <= in_sample;
            ch_r  <= in_chan;
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (k == KW'(TAPS)) begin
            out_sample <= mac_result;
            out_chan   <= ch_r;
            out_valid  <= 1'b1;
            state      <= OUT;
          end else begin
            k <= k + KW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            wp[ch_r]  <= (wp[ch_r] == AW'(TAPS - 1)) ? '0 : wp[ch_r] + AW'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tdm.sv
// Directed and randomized bench for fir_tdm (TAPS=4, CHANNELS=2) against a
// direct-form arithmetic reference model of the filter.
module tb_fir_tdm;

  localparam int TAPS = 4;
  localparam int CHN  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [0:0]  in_chan;
  logic [15:0] in_sample;
  logic        coef_we;
  logic [1:0]  coef_addr;
  logic [15:0] coef_data;
  logic        coef_drop;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_chan;
  logic [15:0] out_sample;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic signed [15:0] m_hist [CHN][TAPS];
  logic signed [15:0] m_coef [TAPS];

  logic [15:0] imp_tbl [4] = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};

  fir_tdm #(
    .BIT_PREC  (16),
    .TAPS      (TAPS),
    .CHANNELS  (CHN),
    .OUT_W     (16),
    .OUT_SHIFT (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_chan    (in_chan),
    .in_sample  (in_sample),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_drop  (coef_drop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_chan   (out_chan),
    .out_sample (out_sample),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // y = round_half_up(sum(c[i]*x[n-i]) / 2^15), then clamp or wrap to 16 bits.
  function automatic logic [15:0] model_out(input int ch);
    longint acc;
    longint r;
    acc = 0;
    for (int i = 0; i < TAPS; i++) acc += longint'(m_coef[i]) * longint'(m_hist[ch][i]);
    r = (acc + 64'sd16384) >>> 15;
`ifdef FIR_SAT_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CHN; c++)
      for (int t = 0; t < TAPS; t++) m_hist[c][t] = '0;
    for (int t = 0; t < TAPS; t++) m_coef[t] = '0;
  endtask

  task automatic wcoef(input int a, input logic [15:0] d);
    coef_we = 1'b1; coef_addr = a[1:0]; coef_data = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
    m_coef[a] = d;
    check("coef_drop_idle", {31'd0, coef_drop}, 32'd0);
  endtask

  // Offer one sample, optionally write a coefficient alongside it or during MAC,
  // optionally hold the result under backpressure, then complete the transfer.
  task automatic do_sample(input int ch, input logic [15:0] s, input int hold,
                           input bit cw, input int ca, input logic [15:0] cd,
                           input int drop_at, output logic [15:0] got);
    int n;
    logic [15:0] exp;
    logic [15:0] held;
    n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_chan = ch[0]; in_sample = s;
    if (cw) begin coef_we = 1'b1; coef_addr = ca[1:0]; coef_data = cd; end
    @(posedge clk); #1;
    in_valid = 1'b0; coef_we = 1'b0;
    if (cw) m_coef[ca] = cd;
    for (int i = TAPS - 1; i > 0; i--) m_hist[ch][i] = m_hist[ch][i-1];
    m_hist[ch][0] = s;
    exp = model_out(ch);
    check("busy_mac", {30'd0, busy, in_ready}, 32'd2);
    n = 0;
    while (n < 20) begin
      if (drop_at > 0 && n == drop_at) begin
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'h5A5A;
      end
      @(posedge clk); #1; n++;
      coef_we = 1'b0;
      if (drop_at > 0 && n == drop_at + 1) check("coef_drop_pulse", {31'd0, coef_drop}, 32'd1);
      if (drop_at > 0 && n == drop_at + 2) check("coef_drop_end", {31'd0, coef_drop}, 32'd0);
      if (out_valid) break;
    end
    check("latency", n, TAPS + 1);
    check("out_sample", {16'd0, out_sample}, {16'd0, exp});
    check("out_chan", {31'd0, out_chan}, ch);
    got  = out_sample;
    held = out_sample;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("bp_hold", {held, 13'd0, out_valid, in_ready, busy}, {out_sample, 16'h0005});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_release", {30'd0, out_valid, in_ready}, 32'd1);
    if (hold > 0) begin
      for (int h = 0; h < 3; h++) begin @(posedge clk); #1; end
      check("bp_single", {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [15:0] got;
    int ch;
    rst = 1'b1; in_valid = 1'b0; in_chan = '0; in_sample = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; out_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {27'd0, in_ready, out_valid, coef_drop, busy, out_chan}, 32'h10);
    check("reset_out", {16'd0, out_sample}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset", {29'd0, in_ready, out_valid, busy}, 32'd4);

    // Impulse response on channel 0
    for (int i = 0; i < 4; i++) wcoef(i, imp_tbl[i]);
    for (int i = 0; i < 4; i++) begin
      do_sample(0, (i == 0) ? 16'h7FFF : 16'h0000, 0, 0, 0, 0, 0, got);
      check("impulse", {16'd0, got}, {16'd0, imp_tbl[i]});
    end

    // Channel isolation: ch0 impulse interleaved with ch1 zeros
    for (int i = 0; i < 4; i++) begin
      do_sample(0, (i == 0) ? 16'h7FFF : 16'h0000, 0, 0, 0, 0, 0, got);
      check("iso_ch0", {16'd0, got}, {16'd0, imp_tbl[i]});
      do_sample(1, 16'h0000, 0, 0, 0, 0, 0, got);
      check("iso_ch1", {16'd0, got}, 32'd0);
    end

    // Backpressure
    do_sample(1, 16'h1234, 10, 0, 0, 0, 0, got);

    // Dropped coefficient write during MAC, then a write paired with an accepted sample
    do_sample(0, 16'h4321, 0, 0, 0, 0, 2, got);
    do_sample(0, 16'h7000, 0, 1, 0, 16'h0100, 0, got);
    do_sample(0, 16'h0800, 0, 1, 1, 16'h8000, 3, got);

    // Randomized traffic with occasional coefficient reloads
    for (int i = 0; i < 24; i++) begin
      if (i % 8 == 0) begin
        for (int t = 0; t < TAPS; t++) wcoef(t, 16'($urandom));
      end
      ch = int'($urandom_range(0, 1));
      do_sample(ch, 16'($urandom), 0, 0, 0, 0, 0, got);
    end

    // Saturation / wrap
    for (int t = 0; t < TAPS; t++) wcoef(t, 16'h7FFF);
    for (int i = 0; i < 4; i++) do_sample(0, 16'h7FFF, 0, 0, 0, 0, 0, got);
`ifdef FIR_SAT_EN
    check("saturate", {16'd0, got}, 32'h7FFF);
`else
    check("wrap", {16'd0, got}, 32'hFFF8);
`endif

    // Reset during MAC cycle 2
    in_valid = 1'b1; in_chan = 1'b0; in_sample = 16'h7FFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async", {29'd0, out_valid, in_ready, busy}, 32'd2);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    check("rst_release", {30'd0, out_valid, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      do_sample(0, (i == 0) ? 16'h7FFF : 16'h0000, 0, 0, 0, 0, 0, got);
      check("zero_coef", {16'd0, got}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
